// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program-counter sequencer for the fetch path. Holds the current
//            instruction address and computes the next one from increment,
//            jump, call and return requests. Calls and returns use a small
//            return-address stack. A one-way RUN -> HALTED state freezes all
//            activity until the next reset.
// Ports    : CLK          rising-edge clock
//            RST_N        asynchronous active-low reset
//            STALL        hold PC, stack and flags this cycle
//            JUMP         PC <- TARGET
//            CALL         push PC+1, then PC <- TARGET
//            RET          PC <- popped return address
//            HALT         enter HALTED (left only by reset)
//            TARGET       jump/call destination
//            PC           current instruction address (registered)
//            PC_INC       PC+1 modulo 2^ADDR_WIDTH (combinational)
//            HALTED       high while halted
//            STACK_EMPTY  return stack holds no entries
//            STACK_OVF    sticky: CALL made while the stack was full
//            STACK_UNF    sticky: RET made while the stack was empty
// Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter int                    ADDR_WIDTH  = 11,
    parameter int                    STACK_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  STALL,
    input  logic                  JUMP,
    input  logic                  CALL,
    input  logic                  RET,
    input  logic                  HALT,
    input  logic [ADDR_WIDTH-1:0] TARGET,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic [ADDR_WIDTH-1:0] PC_INC,
    output logic                  HALTED,
    output logic                  STACK_EMPTY,
    output logic                  STACK_OVF,
    output logic                  STACK_UNF
);

    // Index width addresses the entries; the pointer needs one extra bit so
    // that "full" (pointer == STACK_DEPTH) is distinguishable from "empty".
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    localparam logic [SP_W-1:0]       SP_ONE   = SP_W'(1);
    localparam logic [SP_W-1:0]       SP_FULL  = SP_W'(STACK_DEPTH);
    localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [SP_W-1:0]       sp_q, sp_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];

    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [IDX_W-1:0]      push_idx;
    logic [IDX_W-1:0]      pop_idx;
    logic                  push_en;
    logic                  stack_full;
    logic                  stack_empty;
    logic                  active;

    assign pc_inc      = pc_q + ADDR_ONE;
    assign stack_full  = (sp_q == SP_FULL);
    assign stack_empty = (sp_q == '0);
    // When full, the low index bits are zero, so subtracting one still
    // lands on the last entry.
    assign push_idx    = sp_q[IDX_W-1:0];
    assign pop_idx     = sp_q[IDX_W-1:0] - IDX_ONE;
    // A request is acted on only when running, not halting this edge and
    // not stalled; HALT and STALL swallow every lower-priority request.
    assign active      = (state_q == ST_RUN) && !HALT && !STALL;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_ADDR;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage has no reset: entries beyond the pointer are never read.
    always_ff @(posedge CLK) begin
        if (push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (HALT) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // PC / stack update, priority RET > CALL > JUMP > increment
    // ------------------------------------------------------------------
    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        if (active) begin
            if (RET) begin
                if (!stack_empty) begin
                    pc_d = stack_q[pop_idx];
                    sp_d = sp_q - SP_ONE;
                end else begin
                    pc_d  = pc_inc;
                    unf_d = 1'b1;
                end
            end else if (CALL) begin
                pc_d = TARGET;
                if (!stack_full) begin
                    push_en = 1'b1;
                    sp_d    = sp_q + SP_ONE;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (JUMP) begin
                pc_d = TARGET;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        PC          = pc_q;
        PC_INC      = pc_inc;
        HALTED      = (state_q == ST_HALTED);
        STACK_EMPTY = stack_empty;
        STACK_OVF   = ovf_q;
        STACK_UNF   = unf_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer. A queue-based model of the
//            sequencer is compared against the DUT on every falling edge;
//            directed scenarios add literal expectations, followed by
//            randomized request traffic with occasional resets.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int AW    = 11;
    localparam int DEPTH = 4;
    localparam int AMOD  = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          stall, jump, call, ret, halt;
    logic [AW-1:0] target;
    logic [AW-1:0] pc, pc_inc;
    logic          halted, stack_empty, stack_ovf, stack_unf;

    pc_sequencer #(
        .ADDR_WIDTH (AW),
        .STACK_DEPTH(DEPTH),
        .RESET_ADDR ('0)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .STALL      (stall),
        .JUMP       (jump),
        .CALL       (call),
        .RET        (ret),
        .HALT       (halt),
        .TARGET     (target),
        .PC         (pc),
        .PC_INC     (pc_inc),
        .HALTED     (halted),
        .STACK_EMPTY(stack_empty),
        .STACK_OVF  (stack_ovf),
        .STACK_UNF  (stack_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    int m_pc;
    int m_stack[$];
    bit m_halted, m_ovf, m_unf;
    bit chk_on = 1'b0;

    function automatic void model_reset();
        m_pc = 0;
        m_stack.delete();
        m_halted = 0;
        m_ovf = 0;
        m_unf = 0;
    endfunction

    function automatic void model_step(bit s, bit j, bit c, bit r, bit h, int t);
        if (m_halted) return;
        if (h) begin
            m_halted = 1;
        end else if (s) begin
            // frozen
        end else if (r) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin
                m_pc = (m_pc + 1) % AMOD;
                m_unf = 1;
            end
        end else if (c) begin
            if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + 1) % AMOD);
            else m_ovf = 1;
            m_pc = t;
        end else if (j) begin
            m_pc = t;
        end else begin
            m_pc = (m_pc + 1) % AMOD;
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("pc",          int'(pc),          m_pc);
            check("pc_inc",      int'(pc_inc),      (m_pc + 1) % AMOD);
            check("halted",      int'(halted),      int'(m_halted));
            check("stack_empty", int'(stack_empty), int'(m_stack.size() == 0));
            check("stack_ovf",   int'(stack_ovf),   int'(m_ovf));
            check("stack_unf",   int'(stack_unf),   int'(m_unf));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Drive one request, advance one edge, update the model, settle 1 time unit.
    task automatic cyc(input bit s, input bit j, input bit c, input bit r,
                       input bit h, input int t);
        stall = s; jump = j; call = c; ret = r; halt = h; target = AW'(t);
        @(posedge clk);
        model_step(s, j, c, r, h, t);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        stall = 0; jump = 0; call = 0; ret = 0; halt = 0; target = '0;
        rst_n = 1'b0;
        model_reset();
        #3;
        // Reset values before any clock edge
        check("rst_pc",     int'(pc),          0);
        check("rst_pc_inc", int'(pc_inc),      1);
        check("rst_empty",  int'(stack_empty), 1);
        check("rst_halted", int'(halted),      0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // Reset and increment
        check("inc0", int'(pc), 0);
        for (int i = 1; i <= 3; i++) begin
            idle();
            check("inc_pc",     int'(pc),     i);
            check("inc_pc_inc", int'(pc_inc), i + 1);
        end

        // Wrap-around and jump
        cyc(0, 1, 0, 0, 0, 'h7FE); check("jmp_7fe", int'(pc), 'h7FE);
        idle();                    check("pc_7ff",  int'(pc), 'h7FF);
        check("inc_wrap", int'(pc_inc), 0);
        idle();                    check("wrap0",   int'(pc), 0);
        check("wrap_noflag", int'({stack_ovf, stack_unf}), 0);

        // Nested call/return
        cyc(0, 1, 0, 0, 0, 'h010);
        cyc(0, 0, 1, 0, 0, 'h100); check("call1", int'(pc), 'h100);
        check("call1_empty", int'(stack_empty), 0);
        cyc(0, 0, 1, 0, 0, 'h200); check("call2", int'(pc), 'h200);
        cyc(0, 0, 0, 1, 0, 0);     check("ret1",  int'(pc), 'h101);
        cyc(0, 0, 0, 1, 0, 0);     check("ret2",  int'(pc), 'h011);
        check("ret2_empty", int'(stack_empty), 1);

        // Overflow and underflow
        cyc(0, 1, 0, 0, 0, 'h020);
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 0, 1, 0, 0, 'h300);
            check("ovf_call_pc", int'(pc), 'h300);
            check("ovf_flag", int'(stack_ovf), (i == 5) ? 1 : 0);
        end
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 0, 0, 1, 0, 0);
            check("unf_ret_pc", int'(pc), (i < 4) ? 'h301 : (i == 4) ? 'h021 : 'h022);
            check("unf_flag", int'(stack_unf), (i == 5) ? 1 : 0);
        end

        // Priority and stall
        do_reset();
        cyc(0, 1, 0, 0, 0, 'h050);
        cyc(0, 1, 1, 1, 0, 'h123);
        check("prio_pc",  int'(pc),          'h051);
        check("prio_unf", int'(stack_unf),   1);
        check("prio_emp", int'(stack_empty), 1);
        repeat (3) cyc(1, 1, 0, 0, 0, 'h444);
        check("stall_pc", int'(pc), 'h051);
        cyc(1, 0, 1, 0, 0, 'h555);
        check("stall_call_emp", int'(stack_empty), 1);

        // Halt and reset
        cyc(0, 1, 0, 0, 0, 'h040);
        cyc(0, 0, 0, 0, 1, 0);
        check("halt_pc", int'(pc), 'h040);
        check("halted",  int'(halted), 1);
        cyc(0, 1, 0, 0, 0, 'h500);
        check("halt_hold", int'(pc), 'h040);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_pc",     int'(pc),     0);
        check("async_halted", int'(halted), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Randomized traffic in segments separated by resets
        for (int seg = 0; seg < 8; seg++) begin
            for (int n = 0; n < 300; n++) begin
                int t;
                t = (($urandom_range(0, 3) == 0) ? AMOD - 1 - $urandom_range(0, 3)
                                                 : $urandom_range(0, AMOD - 1));
                cyc($urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 199) == 0,
                    t);
            end
            do_reset();
        end

        chk_on = 1'b0;
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the processor fetch path. Holds the current instruction address and computes the next one from increment, jump, call and return requests. A 4-entry return-address stack supports subroutine calls. The block sits directly upstream of the fetch address multiplexer: its PC_INC output drives the multiplexer's sequential-address input, and its PC output addresses instruction memory.

## Interface

- ADDR_WIDTH, 11, width of every address bus
- STACK_DEPTH, 4, return-address stack entries (power of two, ≥2)
- RESET_ADDR, 0, PC value loaded on reset
- CLK  in  1  system clock, rising-edge active
- RST_N  in  1  asynchronous active-low reset
- STALL  in  1  freeze PC, stack and flags this cycle
- JUMP  in  1  load PC from TARGET
- CALL  in  1  push PC+1 onto the stack, then load PC from TARGET
- RET  in  1  pop the stack top into PC
- HALT  in  1  enter the halted state
- TARGET  in  ADDR_WIDTH  jump/call destination
- PC  out  ADDR_WIDTH  current instruction address (registered)
- PC_INC  out  ADDR_WIDTH  PC+1, modulo 2^ADDR_WIDTH (combinational from PC)
- HALTED  out  1  high while in the HALTED state (registered)
- STACK_EMPTY  out  1  stack holds no entries (registered)
- STACK_OVF  out  1  sticky: a CALL was made while the stack was full
- STACK_UNF  out  1  sticky: a RET was made while the stack was empty

One clock, CLK; reset is RST_N, asynchronous and active-low.

## Operation

- **States:** RUN and HALTED.
  - Reset enters RUN.
  - HALT sampled in RUN moves the block to HALTED.
  - HALTED is left only by reset. In HALTED all inputs are ignored, and PC and the stack hold.
- **Per-edge priority in RUN** (highest first): HALT > STALL > RET > CALL > JUMP > increment.
- **HALT:** the transition to HALTED happens on that edge. PC does not change.
- **STALL:** PC, stack pointer, stack contents and sticky flags all hold.
- **RET, stack non-empty:** PC ← top entry; stack pointer decrements.
- **RET, stack empty:** PC ← PC_INC; STACK_UNF ← 1.
- **CALL, stack not full:** the entry at the stack pointer ← PC_INC; pointer increments; PC ← TARGET.
- **CALL, stack full:** PC ← TARGET; the push is discarded and existing entries are preserved; STACK_OVF ← 1.
- **JUMP:** PC ← TARGET.
- **No request:** PC ← PC_INC.
- **Simultaneous requests:** a lower-priority request asserted with a higher one is dropped entirely and causes no side effect. For example, CALL together with RET pops only.
- **Arithmetic:** increment is unsigned modulo 2^ADDR_WIDTH; all-ones wraps to 0 with no flag.
- **Stack pointer:** ceil(log2(STACK_DEPTH))+1 bits, range 0..STACK_DEPTH.
  - STACK_EMPTY is set when the pointer is 0.
  - Full is when the pointer equals STACK_DEPTH (internal only).
- **Sticky flags:** STACK_OVF and STACK_UNF clear only on reset.

## Timing

- **Reset values** (applied immediately on RST_N low, independent of CLK):
  - PC = RESET_ADDR, so PC_INC = RESET_ADDR+1
  - HALTED = 0, STACK_EMPTY = 1, STACK_OVF = 0, STACK_UNF = 0
  - stack pointer = 0; stack entry contents are don't-care
- **Reset release:** on the first rising edge after RST_N returns high, the block behaves as in RUN.
- **Control sampling:** all controls and TARGET are sampled on the rising edge of CLK. The new PC is visible after that edge, giving one-cycle latency from request to PC.
- **PC_INC:** follows PC combinationally within the same cycle.
- **Flag timing:** HALTED, STACK_EMPTY, STACK_OVF and STACK_UNF update on the same edge as the causing event.
- **Reset mid-operation:** reset asserted in any state, including HALTED or during a stall, returns all state to the reset values. Stack contents are not cleared, but they become unreachable.

## Test plan

- **Reset and increment:** RESET_ADDR=0; release reset and idle 3 cycles. PC must read 0, 1, 2, 3; PC_INC must read 1, 2, 3, 4; STACK_EMPTY=1.
- **Wrap-around and jump:** JUMP with TARGET=0x7FE, then idle 2 cycles. PC must read 0x7FE, then 0x7FF, then 0x000; no flag set.
- **Nested call/return:**
  - At PC=0x010, CALL TARGET=0x100.
  - At 0x100, CALL TARGET=0x200.
  - Then RET, RET.
  - Required PC sequence: 0x100, 0x200, 0x101, 0x011; STACK_EMPTY must be 0 during the calls and 1 at the end.
- **Overflow and underflow:**
  - Five CALLs from PC=0x020, each TARGET=0x300. PC must be 0x300 after each call; STACK_OVF=1 after the fifth.
  - Five RETs: the fifth RET must increment PC and set STACK_UNF=1.
- **Priority and stall:**
  - CALL+RET+JUMP together with an empty stack: pop only, giving PC=old PC+1 and STACK_UNF=1.
  - STALL held 3 cycles with JUMP asserted: PC unchanged, and the JUMP is ignored.
- **Halt and reset:**
  - HALT at PC=0x040, then JUMP TARGET=0x500. PC must hold 0x040 and HALTED=1.
  - Assert RST_N low mid-cycle: PC must be 0 and HALTED=0 immediately, with no clock edge needed.
